// File: rtl/ppu_mem_arbiter_pkg.sv
// rtl/ppu_mem_arbiter_pkg.sv - shared types and constants for the PPU memory arbiter
package ppu_mem_arbiter_pkg;

    // Width of the PPU address space (CHR plus nametables)
    localparam int PPU_AW = 14;

    // Who owns the read data returning from memory next cycle
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_REND   = 2'd1,
        OWN_CPU_RD = 2'd2
    } owner_e;

endpackage

// File: rtl/ppu_mem_arbiter.sv
// rtl/ppu_mem_arbiter.sv - render-priority arbiter for the single-port PPU memory
module ppu_mem_arbiter
    import ppu_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rend_req,
    input  logic [PPU_AW-1:0] rend_addr,
    output logic              rend_gnt,
    output logic              rend_rvalid,
    output logic [7:0]        rend_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [PPU_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,
    output logic [PPU_AW-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_rw,
    input  logic [7:0]        mem_q
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic              pend_q,   pend_d;
    logic              we_q,     we_d;
    logic [PPU_AW-1:0] addr_q,   addr_d;
    logic [7:0]        wdata_q,  wdata_d;
    logic [7:0]        starve_q, starve_d;
    owner_e            owner_q,  owner_d;

    logic force_cpu;
    logic rend_issue;
    logic cpu_issue;

    // Slot arbitration, memory drive, request register and starvation counter next-state
    always_comb begin
        force_cpu  = pend_q && (starve_q == LIMIT);
        rend_issue = rend_req && !force_cpu;
        cpu_issue  = pend_q && !rend_issue;

        rend_gnt = rend_issue;
        mem_addr = '0;
        mem_rw   = 1'b0;
        mem_data = 8'd0;
        if (rend_issue) begin
            mem_addr = rend_addr;
        end else if (cpu_issue) begin
            mem_addr = addr_q;
            mem_rw   = we_q;
            mem_data = wdata_q;
        end

        // The request register only loads when empty, so an issue and a
        // capture can never coincide on the same edge.
        pend_d  = pend_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (cpu_issue) begin
            pend_d = 1'b0;
        end else if (!pend_q && cpu_req) begin
            pend_d  = 1'b1;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
        end

        if (!pend_q || cpu_issue) begin
            starve_d = 8'd0;
        end else if (starve_q == LIMIT) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + 8'd1;
        end

        if (rend_issue) begin
            owner_d = OWN_REND;
        end else if (cpu_issue && !we_q) begin
            owner_d = OWN_CPU_RD;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Route last cycle's read data to whoever issued it
    always_comb begin
        cpu_busy    = pend_q;
        rend_rvalid = (owner_q == OWN_REND);
        cpu_rvalid  = (owner_q == OWN_CPU_RD);
        rend_rdata  = rend_rvalid ? mem_q : 8'd0;
        cpu_rdata   = cpu_rvalid  ? mem_q : 8'd0;
    end

    // State registers; reset drops any pending request and in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 8'd0;
            starve_q <= 8'd0;
            owner_q  <= OWN_NONE;
        end else begin
            pend_q   <= pend_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// tb/tb_ppu_mem_arbiter.sv - self-checking bench for ppu_mem_arbiter
module tb_ppu_mem_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rend_req;
    logic [13:0] rend_addr;
    logic        rend_gnt;
    logic        rend_rvalid;
    logic [7:0]  rend_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_rw;
    logic [7:0]  mem_q;

    ppu_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rend_req(rend_req), .rend_addr(rend_addr), .rend_gnt(rend_gnt),
        .rend_rvalid(rend_rvalid), .rend_rdata(rend_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_rw(mem_rw), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Memory wrapper contents and its registered read output
    logic [7:0] mem_arr [0:16383];
    logic [7:0] nxt_q;

    // Reference model: outstanding CPU request, losses in a row, and the pending return
    bit          m_pend;
    bit          m_we;
    logic [13:0] m_addr;
    logic [7:0]  m_wdata;
    int          m_lost;
    int          m_own;     // 0 none, 1 render, 2 cpu read
    logic [7:0]  m_odata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pend = 0;
        m_lost = 0;
        m_own  = 0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model
    task automatic cycle(input logic rr, input logic [13:0] ra, input logic cr,
                         input logic cw, input logic [13:0] ca, input logic [7:0] cd);
        bit          cpu_wins, r_iss, c_iss;
        logic [13:0] ea;
        logic [7:0]  ed;
        bit          ew;
        @(negedge clk);
        mem_q     = nxt_q;
        rend_req  = rr;
        rend_addr = ra;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        #1;
        cpu_wins = m_pend && (m_lost >= LIMIT);
        r_iss    = rr && !cpu_wins;
        c_iss    = m_pend && !r_iss;
        ea = r_iss ? ra : (c_iss ? m_addr : 14'd0);
        ew = c_iss && m_we;
        ed = c_iss ? m_wdata : 8'd0;

        chk("rend_gnt",    rend_gnt,    r_iss);
        chk("mem_addr",    mem_addr,    ea);
        chk("mem_rw",      mem_rw,      ew);
        chk("mem_data",    mem_data,    ed);
        chk("cpu_busy",    cpu_busy,    m_pend);
        chk("rend_rvalid", rend_rvalid, m_own == 1);
        chk("rend_rdata",  rend_rdata,  (m_own == 1) ? m_odata : 8'd0);
        chk("cpu_rvalid",  cpu_rvalid,  m_own == 2);
        chk("cpu_rdata",   cpu_rdata,   (m_own == 2) ? m_odata : 8'd0);
        chk("rvalid_excl", rend_rvalid && cpu_rvalid, 0);

        // Advance the model past this cycle's edge
        m_own   = r_iss ? 1 : ((c_iss && !m_we) ? 2 : 0);
        m_odata = mem_arr[ea];
        if (c_iss || !m_pend) m_lost = 0;
        else if (m_lost < LIMIT) m_lost = m_lost + 1;
        if (c_iss) begin
            m_pend = 0;
        end else if (!m_pend && cr) begin
            m_pend  = 1;
            m_we    = cw;
            m_addr  = ca;
            m_wdata = cd;
        end

        // Memory wrapper responds to what the DUT actually drove
        nxt_q = mem_arr[mem_addr];
        if (mem_rw) mem_arr[mem_addr] = mem_data;
    endtask

    task automatic idle();
        cycle(0, 14'd0, 0, 0, 14'd0, 8'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rend_gnt"},    rend_gnt,    0);
        chk({tag, "_rend_rvalid"}, rend_rvalid, 0);
        chk({tag, "_rend_rdata"},  rend_rdata,  0);
        chk({tag, "_cpu_busy"},    cpu_busy,    0);
        chk({tag, "_cpu_rvalid"},  cpu_rvalid,  0);
        chk({tag, "_cpu_rdata"},   cpu_rdata,   0);
        chk({tag, "_mem_addr"},    mem_addr,    0);
        chk({tag, "_mem_data"},    mem_data,    0);
        chk({tag, "_mem_rw"},      mem_rw,      0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rend_req = 0;
        cpu_req  = 0;
        rst_n    = 0;
        #1;
        check_all_zero("rst");
        model_clear();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        bit          saw;
        logic [13:0] ra;
        int          load;

        rst_n = 0;
        rend_req = 0; rend_addr = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_q = 0; nxt_q = 0;
        for (int i = 0; i < 16384; i++) mem_arr[i] = 8'($urandom);
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // Uncontended CPU read
        mem_arr[14'h2005] = 8'h5A;
        cycle(0, 14'd0, 1, 0, 14'h2005, 8'd0);
        chk("rd_busy_before", cpu_busy, 0);
        idle();
        chk("rd_busy_issue", cpu_busy, 1);
        chk("rd_issue_addr", mem_addr, 14'h2005);
        idle();
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", cpu_rdata, 8'h5A);
        chk("rd_busy_after", cpu_busy, 0);

        // Uncontended CPU write
        cycle(0, 14'd0, 1, 1, 14'h2400, 8'hC3);
        idle();
        chk("wr_rw", mem_rw, 1);
        chk("wr_addr", mem_addr, 14'h2400);
        chk("wr_data", mem_data, 8'hC3);
        idle();
        chk("wr_no_rvalid", cpu_rvalid, 0);
        chk("wr_mem", mem_arr[14'h2400], 8'hC3);

        // Render priority with starvation guard
        cycle(1, 14'h0123, 1, 0, 14'h2007, 8'd0);
        for (int k = 0; k < 11; k++) begin
            cycle(1, 14'(k + 14'h0200), 0, 0, 14'd0, 8'd0);
            chk("prio_gnt", rend_gnt, (k != LIMIT));
            if (k == LIMIT) chk("prio_cpu_addr", mem_addr, 14'h2007);
        end
        idle();

        // Interleaved render and CPU reads
        mem_arr[14'h0010] = 8'h11;
        mem_arr[14'h23C0] = 8'h22;
        cycle(1, 14'h0010, 1, 0, 14'h23C0, 8'd0);
        idle();
        chk("il_rend_rvalid", rend_rvalid, 1);
        chk("il_rend_rdata", rend_rdata, 8'h11);
        chk("il_cpu_idle", cpu_rvalid, 0);
        idle();
        chk("il_cpu_rvalid", cpu_rvalid, 1);
        chk("il_cpu_rdata", cpu_rdata, 8'h22);
        chk("il_rend_idle", rend_rvalid, 0);

        // Request while busy is dropped
        saw = 0;
        cycle(1, 14'h0100, 1, 0, 14'h2100, 8'd0);
        cycle(1, 14'h0100, 1, 0, 14'h2001, 8'd0);
        if (mem_addr == 14'h2001) saw = 1;
        for (int k = 0; k < 14; k++) begin
            cycle(k < 4, 14'h0100, 0, 0, 14'd0, 8'd0);
            if (mem_addr == 14'h2001) saw = 1;
        end
        chk("drop_no_2001", saw, 0);

        // Reset with a CPU read pending under render load and a render read in flight
        cycle(1, 14'h0300, 1, 0, 14'h2222, 8'd0);
        repeat (3) cycle(1, 14'h0301, 0, 0, 14'd0, 8'd0);
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            idle();
            chk("post_rst_rend_rvalid", rend_rvalid, 0);
            chk("post_rst_cpu_rvalid", cpu_rvalid, 0);
        end

        // Randomized traffic at varying render load
        for (int blk = 0; blk < 8; blk++) begin
            load = (blk % 4 == 0) ? 0 : (blk % 4 == 1) ? 30 : (blk % 4 == 2) ? 75 : 100;
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 699) == 0) apply_reset();
                ra = 14'($urandom);
                cycle($urandom_range(0, 99) < load, ra, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1, 14'($urandom), 8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
